pll_lock_reset_sequencer: RTL
=============================

# pll_lock_reset_sequencer

Sits beside the 310 MHz→10 MHz OFDM clock PLL and gates the datapath on it. It drives the PLL's active-high reset and watches its asynchronous `locked` output, qualifying lock before releasing staged resets to the downstream OFDM clock domains. On loss of lock it re-asserts all domain resets and restarts the PLL. If lock never arrives, it retries the PLL after a timeout. Runs on the free-running reference clock, never on a PLL output.

## Interface
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer (≥2).
- `PLL_RST_CYCLES`, 8: cycles `pll_rst` is held high per PLL reset pulse.
- `LOCK_TIMEOUT`, 65535: cycles in WAIT_LOCK before the PLL is retried.
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release.
- `RELEASE_GAP`, 16: cycles between successive domain releases.
- `NUM_DOMAINS`, 3: number of staged domain resets.
- `CNT_W`, 8: width of the status counters.
---
- `clk`  in  1  free-running reference clock (same source as PLL `refclk`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL `locked`; asynchronous to `clk`.
- `sw_restart`  in  1  synchronous one-cycle request to restart the whole sequence.
- `pll_rst`  out  1  active-high reset to the PLL.
- `dom_rst_n`  out  NUM_DOMAINS  per-domain active-low resets. Registered and glitch-free. Each consumer re-synchronizes deassertion.
- `ready`  out  1  high only in RUN.
- `lock_loss_cnt`  out  CNT_W  saturating count of lock losses after RUN/RELEASE was reached.
- `retry_cnt`  out  CNT_W  saturating count of WAIT_LOCK timeouts.
- `state_o`  out  3  current FSM state encoding.

## Operation
- `locked_s` is `pll_locked` after `SYNC_STAGES` flops.
- One shared down-counter, reloaded on every state entry.
- **PLL_RST:** `pll_rst`=1 and all `dom_rst_n`=0. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0.
  - `locked_s`=1 → STABLE.
  - Counter expires after `LOCK_TIMEOUT` cycles → PLL_RST and `retry_cnt`++.
  - If both happen in the same cycle, lock wins.
- **STABLE:** `locked_s`=0 → WAIT_LOCK with the counter reloaded. After `STABLE_CYCLES` consecutive cycles of `locked_s`=1 → RELEASE.
- **RELEASE:**
  - `dom_rst_n[i]` rises i×`RELEASE_GAP` cycles after entry, in index order 0..NUM_DOMAINS-1.
  - `RELEASE_GAP` cycles after the last release → RUN.
- **RUN:** `ready`=1.
- **LOSS:** entered from RELEASE or RUN when `locked_s`=0.
  - On the entry edge: all `dom_rst_n`=0, `ready`=0, `lock_loss_cnt`++.
  - Next state is PLL_RST; LOSS lasts exactly one cycle.
- **sw_restart:** from any state other than PLL_RST → PLL_RST on the next edge, with all domains asserted.
  - sw_restart has priority over lock loss; the loss is then not counted.
  - Ignored while already in PLL_RST; the counter is not reloaded.
- Counters saturate at 2^CNT_W−1 and clear only on `rst_n`.

## Timing
- **Reset values:** state PLL_RST, `pll_rst`=1, `dom_rst_n`=0, `ready`=0, both counters 0, `state_o`=PLL_RST.
- **Lock detection latency:** `pll_locked` rise → STABLE entry takes SYNC_STAGES+1 cycles.
- **Earliest release:** first `dom_rst_n[0]` rise is `STABLE_CYCLES` cycles after STABLE entry.
- **Loss latency:** `pll_locked` fall → `dom_rst_n` all low takes SYNC_STAGES+1 cycles.
- **Reset mid-operation:** `rst_n` low asynchronously forces the reset values; sequencing restarts at PLL_RST on release.
- All outputs are registered. Domain resets never glitch high outside RELEASE/RUN.

## Configuration
- **`PLL_SEQ_STATUS_EN` defined:** `lock_loss_cnt`, `retry_cnt` and `state_o` are live.
- **Not defined:** the status counters are not built and the three ports are tied to 0. Sequencing behaviour is identical.

## Structure
- **Package `pll_seq_pkg`:**
  - state enum: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, LOSS=5;
  - default parameter constants;
  - counter width function (clog2 of the max of the cycle parameters).
- **Sub-module `pll_lock_sync`:** parameterized `SYNC_STAGES` bit synchronizer with async active-low clear to 0.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, RELEASE_GAP=4, NUM_DOMAINS=3, SYNC_STAGES=2.

- **Clean lock:** `pll_locked` high 10 cycles after `rst_n` rises.
  - → `pll_rst` low after 4 cycles.
  - → `dom_rst_n` steps 001, 011, 111 at 4-cycle spacing.
  - → `ready`=1 4 cycles later.
- **Glitchy lock:** `pll_locked` high 5 cycles, low 1, then high.
  - → STABLE restarts.
  - → release occurs 8 cycles after the final rise is synchronized.
- **No lock:** `pll_locked` held 0.
  - → `pll_rst` pulses 4 cycles every 36 cycles.
  - → `retry_cnt` counts 1, 2, 3.
- **Loss in RUN:** drop `pll_locked`.
  - → 3 cycles later `dom_rst_n`=000 and `ready`=0.
  - → `lock_loss_cnt`=1.
  - → `pll_rst` high next cycle.
- **Restart vs loss:** `sw_restart` in the same cycle that `locked_s` falls in RUN.
  - → PLL_RST entered.
  - → `lock_loss_cnt` unchanged.
- **Async reset mid-RELEASE:** `rst_n` low with `dom_rst_n`=011.
  - → immediately 000, `pll_rst`=1.
  - → counters 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock / staged reset sequencer.
// State encoding, default parameter values and the timer width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    LOSS      = 3'd5
  } state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 8;
  localparam int DEF_LOCK_TIMEOUT   = 65535;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_RELEASE_GAP    = 16;
  localparam int DEF_NUM_DOMAINS    = 3;
  localparam int DEF_CNT_W          = 8;

  // The shared timer holds (cycles - 1), so clog2 of the largest period suffices.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer for a single asynchronous level (PLL locked).
// Clears to 0 on rst_n so a stale lock is never seen after reset.
module pll_lock_sync
  #(parameter int STAGES = 2)
  (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
  );

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Drives the PLL reset, qualifies its lock and releases staged domain resets.
// Status outputs (lock_loss_cnt, retry_cnt, state_o) are live only with PLL_SEQ_STATUS_EN.
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
  #(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int RELEASE_GAP    = DEF_RELEASE_GAP,
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int CNT_W          = DEF_CNT_W
  )
  (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   sw_restart,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   ready,
    output logic [CNT_W-1:0]       lock_loss_cnt,
    output logic [CNT_W-1:0]       retry_cnt,
    output logic [2:0]             state_o
  );

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP);
  localparam logic [CW-1:0] RST_RELOAD    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_RELOAD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_RELOAD = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RELOAD    = CW'(RELEASE_GAP - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   locked_s;

  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    dom_d   = dom_q;

    unique case (state_q)
      PLL_RST:   if (cnt_q == '0) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock is tested first so it wins over a simultaneous timeout.
        if (locked_s)          state_d = STABLE;
        else if (cnt_q == '0)  state_d = PLL_RST;
      end
      STABLE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == '0) begin
          state_d = RELEASE;
          dom_d   = NUM_DOMAINS'(1);
        end
      end
      RELEASE: begin
        if (!locked_s) state_d = LOSS;
        else if (cnt_q == '0) begin
          if (&dom_q) state_d = RUN;
          else begin
            // Shift in the next domain in index order and restart the gap.
            dom_d = (dom_q << 1) | NUM_DOMAINS'(1);
            cnt_d = GAP_RELOAD;
          end
        end
      end
      RUN:     if (!locked_s) state_d = LOSS;
      LOSS:    state_d = PLL_RST;
      default: state_d = PLL_RST;
    endcase

    if (sw_restart && (state_q != PLL_RST)) state_d = PLL_RST;

    if (state_d != state_q) begin
      unique case (state_d)
        PLL_RST:   cnt_d = RST_RELOAD;
        WAIT_LOCK: cnt_d = LOCK_RELOAD;
        STABLE:    cnt_d = STABLE_RELOAD;
        RELEASE:   cnt_d = GAP_RELOAD;
        default:   cnt_d = '0;
      endcase
    end

    // Domains may only be out of reset while releasing or running.
    if (!(state_d inside {RELEASE, RUN})) dom_d = '0;
    pll_rst_d = (state_d == PLL_RST);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PLL_RST;
      cnt_q     <= RST_RELOAD;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign dom_rst_n = dom_q;
  assign ready     = ready_q;

`ifdef PLL_SEQ_STATUS_EN
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d, retry_cnt_q, retry_cnt_d;

  // A restart pre-empting a loss or timeout is not counted as either.
  always_comb begin
    loss_cnt_d  = loss_cnt_q;
    retry_cnt_d = retry_cnt_q;
    if ((state_d == LOSS) && (loss_cnt_q != '1))
      loss_cnt_d = loss_cnt_q + 1'b1;
    if ((state_q == WAIT_LOCK) && (state_d == PLL_RST) && !sw_restart && (retry_cnt_q != '1))
      retry_cnt_d = retry_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      loss_cnt_q  <= loss_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
  assign retry_cnt     = retry_cnt_q;
  assign state_o       = state_q;
`else
  assign lock_loss_cnt = '0;
  assign retry_cnt     = '0;
  assign state_o       = '0;
`endif

endmodule
